// File: rtl/bbc_pkg.sv
// rtl/bbc_pkg.sv - shared mode/state encodings and datapath widths for buck_boost_ctrl
package bbc_pkg;

  // Mode encodings are also decoded by the PWM generator's bridge drive logic.
  localparam logic [1:0] MODE_OFF        = 2'b00;
  localparam logic [1:0] MODE_BUCK       = 2'b01;
  localparam logic [1:0] MODE_BOOST      = 2'b10;
  localparam logic [1:0] MODE_BUCK_BOOST = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SOFT  = 2'b01;
  localparam logic [1:0] ST_RUN   = 2'b10;
  localparam logic [1:0] ST_FAULT = 2'b11;

  localparam int ACC_W = 22;
  localparam logic signed [ACC_W-1:0] ACC_LIM = 22'sd1048576;

endpackage

// File: rtl/bbc_mode_sel.sv
// rtl/bbc_mode_sel.sv - hysteretic buck / boost / buck-boost topology decision
module bbc_mode_sel
  import bbc_pkg::*;
#(
  parameter int ADC_W = 12,
  parameter int HYST  = 32
) (
  input  logic [ADC_W-1:0] vin,
  input  logic [ADC_W-1:0] vref,
  input  logic [1:0]       cur_mode,
  output logic [1:0]       mode
);

  localparam int W = ADC_W + 3;

  logic signed [W-1:0] vin_s;
  logic signed [W-1:0] vref_s;
  logic signed [W-1:0] vref2_s;
  logic signed [W-1:0] hyst_s;
  logic                buck;
  logic                boost;

  assign vin_s   = signed'({3'b000, vin});
  assign vref_s  = signed'({3'b000, vref});
  assign vref2_s = vref_s <<< 1;
  assign hyst_s  = W'(HYST);

  // The inner threshold only applies while already in that mode, so OFF gets no hysteresis.
  assign buck  = (vin_s > vref2_s + hyst_s) ||
                 ((cur_mode == MODE_BUCK) && (vin_s > vref2_s - hyst_s));
  assign boost = (vin_s < vref_s - hyst_s) ||
                 ((cur_mode == MODE_BOOST) && (vin_s < vref_s + hyst_s));

  assign mode = buck ? MODE_BUCK : (boost ? MODE_BOOST : MODE_BUCK_BOOST);

endmodule

// File: rtl/buck_boost_ctrl.sv
// rtl/buck_boost_ctrl.sv - PWM-period-synchronous PI duty controller with soft-start and fault latch
module buck_boost_ctrl
  import bbc_pkg::*;
#(
  parameter int ADC_W     = 12,
  parameter int KP_SHIFT  = 3,
  parameter int KI_SHIFT  = 6,
  parameter int HYST      = 32,
  parameter int OV_MARGIN = 200,
  parameter int UVLO      = 100,
  parameter int DUTY_MIN  = 8,
  parameter int DUTY_MAX  = 240,
  parameter int SS_STEP   = 1
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [ADC_W-1:0] adc_vin,
  input  logic [ADC_W-1:0] adc_vout,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] vref,
  input  logic             pwm_clk,
  output logic [7:0]       Duty,
  output logic [1:0]       Mode,
  output logic             fault,
  output logic [1:0]       state
);

  localparam logic [7:0]             D_MIN = 8'(DUTY_MIN);
  localparam logic [7:0]             D_MAX = 8'(DUTY_MAX);
  localparam logic signed [ACC_W-1:0] LO_LIM = ACC_W'(DUTY_MIN);
  localparam logic signed [ACC_W-1:0] MID    = ACC_W'(128);
  localparam logic [ADC_W+1:0]       OV_M   = (ADC_W+2)'(OV_MARGIN);
  localparam logic [ADC_W-1:0]       UV_M   = ADC_W'(UVLO);

  logic                    pwm_q;
  logic                    upd;
  logic [ADC_W-1:0]        vin_q;
  logic [ADC_W-1:0]        vout_q;
  logic                    have_sample;
  logic signed [ACC_W-1:0] acc;
  logic [7:0]              ss_lim;
  logic [1:0]              mode_sel;

  // Counter wrap: period MSB falls from 1 to 0.
  assign upd = pwm_q & ~pwm_clk;

  bbc_mode_sel #(.ADC_W(ADC_W), .HYST(HYST)) u_mode_sel (
    .vin      (vin_q),
    .vref     (vref),
    .cur_mode (Mode),
    .mode     (mode_sel)
  );

  logic [ADC_W+1:0] ov_lim;
  logic             trip;
  assign ov_lim = {2'b00, vref} + OV_M;
  assign trip   = ({2'b00, vout_q} > ov_lim) || (vin_q < UV_M);

  logic [8:0] ss_sum;
  logic [7:0] ss_nxt;
  logic [7:0] ss_cur;
  logic [7:0] ceil;
  assign ss_sum = {1'b0, ss_lim} + 9'(SS_STEP);
  assign ss_nxt = ss_sum[8] ? 8'hFF : ss_sum[7:0];
  assign ss_cur = (state == ST_SOFT) ? ss_nxt : ss_lim;
  assign ceil   = (ss_cur < D_MAX) ? ss_cur : D_MAX;

  logic signed [ADC_W:0]   e13;
  logic signed [ACC_W-1:0] e;
  logic signed [ACC_W-1:0] u;
  logic signed [ACC_W-1:0] hi_lim;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_nxt;
  logic                    sat_hi;
  logic                    sat_lo;
  logic                    hold_acc;
  logic [7:0]              duty_pi;

  assign e13     = signed'({1'b0, vref}) - signed'({1'b0, vout_q});
  assign e       = {{(ACC_W-ADC_W-1){e13[ADC_W]}}, e13};
  assign u       = (e >>> KP_SHIFT) + (acc >>> KI_SHIFT) + MID;
  assign hi_lim  = {{(ACC_W-8){1'b0}}, ceil};
  assign sat_hi  = u > hi_lim;
  assign sat_lo  = u < LO_LIM;
  assign duty_pi = sat_hi ? ceil : (sat_lo ? D_MIN : u[7:0]);

  // Integrate only when the error would pull the output back inside the clamp.
  assign hold_acc = (sat_hi && !e[ACC_W-1]) || (sat_lo && e[ACC_W-1]);
  assign acc_sum  = acc + e;
  assign acc_nxt  = (acc_sum > ACC_LIM) ? ACC_LIM :
                    ((acc_sum < -ACC_LIM) ? -ACC_LIM : acc_sum);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q       <= 1'b0;
      vin_q       <= '0;
      vout_q      <= '0;
      have_sample <= 1'b0;
      acc         <= '0;
      ss_lim      <= D_MIN;
      Duty        <= 8'd0;
      Mode        <= MODE_OFF;
      fault       <= 1'b0;
      state       <= ST_IDLE;
    end else begin
      pwm_q <= pwm_clk;
      if (adc_valid) begin
        vin_q  <= adc_vin;
        vout_q <= adc_vout;
      end
      if (!en)            have_sample <= 1'b0;
      else if (adc_valid) have_sample <= 1'b1;

      if (!en) begin
        state  <= ST_IDLE;
        Duty   <= 8'd0;
        Mode   <= MODE_OFF;
        fault  <= 1'b0;
        acc    <= '0;
        ss_lim <= D_MIN;
      end else if (upd) begin
        case (state)
          ST_IDLE: begin
            if (have_sample) begin
              state  <= ST_SOFT;
              Mode   <= mode_sel;
              Duty   <= D_MIN;
              acc    <= '0;
              ss_lim <= D_MIN;
            end
          end
          ST_SOFT, ST_RUN: begin
            if (trip) begin
              state <= ST_FAULT;
              fault <= 1'b1;
              Mode  <= MODE_OFF;
              Duty  <= 8'd0;
              acc   <= '0;
            end else begin
              if (state == ST_SOFT) begin
                ss_lim <= ss_nxt;
                if (ss_nxt >= D_MAX) state <= ST_RUN;
              end
              if (mode_sel != Mode) begin
                Mode <= mode_sel;
                Duty <= D_MIN;
                acc  <= '0;
              end else begin
                Duty <= duty_pi;
                if (!hold_acc) acc <= acc_nxt;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buck_boost_ctrl.sv
// tb/tb_buck_boost_ctrl.sv - directed self-checking bench for buck_boost_ctrl
module tb_buck_boost_ctrl;

  logic        sys_clk   = 1'b0;
  logic        rst_n     = 1'b0;
  logic        en        = 1'b0;
  logic        adc_valid = 1'b0;
  logic [11:0] adc_vin   = '0;
  logic [11:0] adc_vout  = '0;
  logic [11:0] vref      = '0;
  logic [2:0]  pcnt      = '0;
  logic        pwm_clk;
  logic [7:0]  Duty;
  logic [1:0]  Mode;
  logic        fault;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  // Stand-in PWM counter: 8 sys_clk cycles per period, MSB drives pwm_clk.
  always @(posedge sys_clk) pcnt <= pcnt + 3'd1;
  assign pwm_clk = pcnt[2];

  buck_boost_ctrl dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .en        (en),
    .adc_vin   (adc_vin),
    .adc_vout  (adc_vout),
    .adc_valid (adc_valid),
    .vref      (vref),
    .pwm_clk   (pwm_clk),
    .Duty      (Duty),
    .Mode      (Mode),
    .fault     (fault),
    .state     (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic expect_out(input string tag, input int d, input int m, input int s);
    check({tag, "_duty"},  32'(Duty),  32'(d));
    check({tag, "_mode"},  32'(Mode),  32'(m));
    check({tag, "_state"}, 32'(state), 32'(s));
  endtask

  // Leaves the bench at the negedge inside the update cycle (pcnt == 0).
  task automatic wait_upd_cycle();
    int n = 0;
    @(negedge sys_clk);
    while (pcnt != 3'd0 && n < 16) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 16) begin
      total++;
      bad++;
      $error("FAIL upd_timeout observed=%0d expected=<16", n);
    end
  endtask

  task automatic next_update();
    wait_upd_cycle();
    @(negedge sys_clk);
  endtask

  task automatic sample(input logic [11:0] vi, input logic [11:0] vo);
    adc_vin   = vi;
    adc_vout  = vo;
    adc_valid = 1'b1;
    @(negedge sys_clk);
    adc_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    expect_out("reset", 0, 0, 0);
    check("reset_fault", 32'(fault), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      next_update();
      expect_out($sformatf("idle%0d", i), 0, 0, 0);
    end

    vref = 12'd1000;
    en   = 1'b1;
    sample(12'd3000, 12'd0);
    next_update();
    expect_out("ss_entry", 8, 1, 1);
    for (int k = 1; k <= 232; k++) begin
      next_update();
      check($sformatf("ramp%0d_duty", k), 32'(Duty), 32'(8 + k));
      if (k >= 231) check($sformatf("ramp%0d_state", k), 32'(state), (k == 232) ? 32'd2 : 32'd1);
    end

    repeat (268) next_update();
    expect_out("sat_hold", 240, 1, 2);
    sample(12'd3000, 12'd1000);
    next_update();
    check("unwind1", 32'(Duty), 128);
    next_update();
    check("unwind2", 32'(Duty), 128);

    sample(12'd3000, 12'd1016);
    next_update();
    check("pi_a", 32'(Duty), 126);
    next_update();
    check("pi_b", 32'(Duty), 125);
    next_update();
    check("pi_c", 32'(Duty), 125);
    sample(12'd3000, 12'd1000);
    next_update();
    check("pi_d", 32'(Duty), 127);

    sample(12'd2040, 12'd1000);
    next_update();
    expect_out("hy2040", 127, 1, 2);
    sample(12'd1980, 12'd1000);
    next_update();
    expect_out("hy1980", 127, 1, 2);
    sample(12'd1960, 12'd1000);
    next_update();
    expect_out("hy1960", 8, 3, 2);
    next_update();
    expect_out("hy1960b", 128, 3, 2);
    sample(12'd980, 12'd1000);
    next_update();
    expect_out("hy980", 128, 3, 2);
    sample(12'd960, 12'd1000);
    next_update();
    expect_out("hy960", 8, 2, 2);
    sample(12'd990, 12'd1000);
    next_update();
    expect_out("hy990", 128, 2, 2);

    sample(12'd990, 12'd1016);
    next_update();
    check("coinc_pre", 32'(Duty), 126);
    wait_upd_cycle();
    adc_vout  = 12'd1000;
    adc_valid = 1'b1;
    @(negedge sys_clk);
    adc_valid = 1'b0;
    check("coinc_old", 32'(Duty), 125);
    next_update();
    check("coinc_new", 32'(Duty), 127);

    sample(12'd990, 12'd1250);
    next_update();
    expect_out("ov_trip", 0, 0, 3);
    check("ov_fault", 32'(fault), 1);
    sample(12'd990, 12'd900);
    next_update();
    expect_out("ov_hold", 0, 0, 3);
    check("ov_fault_hold", 32'(fault), 1);
    en = 1'b0;
    @(negedge sys_clk);
    expect_out("ov_clear", 0, 0, 0);
    check("ov_fault_clear", 32'(fault), 0);

    en = 1'b1;
    sample(12'd3000, 12'd0);
    next_update();
    expect_out("re_entry", 8, 1, 1);
    next_update();
    check("re_ramp", 32'(Duty), 9);
    wait_upd_cycle();
    en = 1'b0;
    @(negedge sys_clk);
    expect_out("en_fall", 0, 0, 0);

    en = 1'b1;
    sample(12'd3000, 12'd0);
    next_update();
    expect_out("rst_pre", 8, 1, 1);
    @(negedge sys_clk);
    rst_n = 1'b0;
    #1;
    expect_out("rst_async", 0, 0, 0);
    check("rst_async_fault", 32'(fault), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
